// File: rtl/csync_generator_pal576i.sv
// PAL 576i composite sync generator: half-line timing counters drive registered
// csync, hsync/vsync strobes, field flag, line number and active-video window.
module csync_generator_pal576i #(
  parameter int LINE_CLKS    = 6144,
  parameter int HSYNC_CLKS   = 451,
  parameter int EQ_CLKS      = 226,
  parameter int BROAD_CLKS   = 2621,
  parameter int ACTIVE_START = 1008,
  parameter int ACTIVE_END   = 6000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frameSync,
  output logic       csync,
  output logic       hsync,
  output logic       vsync,
  output logic       isFieldOdd,
  output logic [9:0] lineNumber,
  output logic       activeVideo
);

  localparam int C_W = $clog2(LINE_CLKS);
  localparam logic [C_W-1:0] HALF_C  = C_W'(LINE_CLKS / 2);
  localparam logic [C_W-1:0] HALF_M1 = C_W'(LINE_CLKS / 2 - 1);

  logic [C_W-1:0] c_q, c_d;
  logic [10:0]    h_q, h_d;
  logic           csync_q, csync_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           isFieldOdd_q, isFieldOdd_d;
  logic [9:0]     lineNumber_q, lineNumber_d;
  logic           activeVideo_q, activeVideo_d;

  logic [9:0]     line_cur;
  logic [C_W-1:0] pos;
  logic           c_zero;

  // Low width of the pulse that starts at the beginning of half-line h.
  function automatic logic [C_W-1:0] pulse_width(input logic [10:0] h);
    if (h <= 11'd4 || (h >= 11'd625 && h <= 11'd629))
      return C_W'(BROAD_CLKS);
    if (h >= 11'd1245 || (h >= 11'd5 && h <= 11'd9) ||
        (h >= 11'd620 && h <= 11'd624) || (h >= 11'd630 && h <= 11'd634))
      return C_W'(EQ_CLKS);
    if (!h[0])
      return C_W'(HSYNC_CLKS);
    return '0;
  endfunction

  function automatic logic in_picture_lines(input logic [9:0] line);
    return (line >= 10'd23 && line <= 10'd310) || (line >= 10'd336 && line <= 10'd622);
  endfunction

  always_comb begin
    c_d = c_q + 1'b1;
    h_d = h_q;
    if (c_q == HALF_M1) begin
      c_d = '0;
      h_d = (h_q == 11'd1249) ? 11'd0 : h_q + 11'd1;
    end
    if (frameSync) begin
      c_d = '0;
      h_d = '0;
    end

    line_cur = h_q[10:1] + 10'd1;
    c_zero   = (c_q == '0);
    // Position within the full line; odd half-lines sit in the second half.
    pos      = c_q + (h_q[0] ? HALF_C : '0);

    csync_d = !(c_q < pulse_width(h_q));
    hsync_d = c_zero && !h_q[0];
    vsync_d = c_zero && (h_q == 11'd0 || h_q == 11'd625);

    isFieldOdd_d = isFieldOdd_q;
    if (c_zero && h_q == 11'd0)
      isFieldOdd_d = 1'b1;
    else if (c_zero && h_q == 11'd625)
      isFieldOdd_d = 1'b0;

    lineNumber_d = hsync_d ? line_cur : lineNumber_q;

    activeVideo_d = in_picture_lines(line_cur) &&
                    (pos >= C_W'(ACTIVE_START)) && (pos < C_W'(ACTIVE_END));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q           <= '0;
      h_q           <= '0;
      csync_q       <= 1'b1;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      isFieldOdd_q  <= 1'b1;
      lineNumber_q  <= 10'd1;
      activeVideo_q <= 1'b0;
    end else begin
      c_q           <= c_d;
      h_q           <= h_d;
      csync_q       <= csync_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      isFieldOdd_q  <= isFieldOdd_d;
      lineNumber_q  <= lineNumber_d;
      activeVideo_q <= activeVideo_d;
    end
  end

  assign csync       = csync_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign isFieldOdd  = isFieldOdd_q;
  assign lineNumber  = lineNumber_q;
  assign activeVideo = activeVideo_q;

endmodule

// File: tb/tb_csync_generator_pal576i.sv
// Directed bench for csync_generator_pal576i using a scaled-down line
// (32 clks per line, 16 per half-line) so a full 625-line frame stays short.
module tb_csync_generator_pal576i;

  logic       clk = 1'b0;
  logic       reset;
  logic       frameSync;
  logic       csync, hsync, vsync, isFieldOdd, activeVideo;
  logic [9:0] lineNumber;

  int errors = 0;
  int checks = 0;
  int s_obs  = 0;   // half-line state index (h*16+c) the outputs currently reflect
  int act_cnt = 0;

  csync_generator_pal576i #(
    .LINE_CLKS(32), .HSYNC_CLKS(3), .EQ_CLKS(2), .BROAD_CLKS(13),
    .ACTIVE_START(6), .ACTIVE_END(30)
  ) dut (
    .clk(clk), .reset(reset), .frameSync(frameSync), .csync(csync),
    .hsync(hsync), .vsync(vsync), .isFieldOdd(isFieldOdd),
    .lineNumber(lineNumber), .activeVideo(activeVideo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at state %0d",
               tag, got, got, exp, exp, s_obs);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    s_obs++;
  endtask

  task automatic goto(input int target);
    while (s_obs < target) adv();
    if (s_obs != target) chk("goto", 32'(s_obs), 32'(target));
  endtask

  // Captures csync over one half-line, bit c = csync at c; also accumulates activeVideo.
  task automatic check_half(input int h, input logic [15:0] exp_pat);
    logic [15:0] pat;
    goto(h * 16);
    for (int c = 0; c < 16; c++) begin
      if (c != 0) adv();
      pat[c] = csync;
      act_cnt += 32'(activeVideo);
    end
    chk($sformatf("csync_half_%0d", h), 32'(pat), 32'(exp_pat));
  endtask

  task automatic count_active(input int line, input int exp);
    int n;
    goto((line - 1) * 32);
    n = 32'(activeVideo);
    for (int i = 1; i < 32; i++) begin
      adv();
      n += 32'(activeVideo);
    end
    chk($sformatf("active_line_%0d", line), 32'(n), 32'(exp));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_csync"}, 32'(csync), 1);
    chk({tag, "_hsync"}, 32'(hsync), 0);
    chk({tag, "_vsync"}, 32'(vsync), 0);
    chk({tag, "_field"}, 32'(isFieldOdd), 1);
    chk({tag, "_line"}, 32'(lineNumber), 1);
    chk({tag, "_active"}, 32'(activeVideo), 0);
  endtask

  initial begin
    reset = 1'b1;
    frameSync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Release: first edge after release produces outputs for state 0.
    reset = 1'b0;
    s_obs = -1;
    adv();
    chk("start_vsync", 32'(vsync), 1);
    chk("start_hsync", 32'(hsync), 1);
    chk("start_line", 32'(lineNumber), 1);
    chk("start_field", 32'(isFieldOdd), 1);
    for (int h = 0; h < 5; h++) check_half(h, 16'hE000);
    chk("vsync_once", 32'(vsync), 0);
    for (int h = 5; h < 10; h++) check_half(h, 16'hFFFC);

    goto(160);
    chk("hsync_line6", 32'(hsync), 1);
    chk("line6", 32'(lineNumber), 6);
    check_half(10, 16'hFFF8);
    check_half(11, 16'hFFFF);
    goto(192);
    chk("hsync_line7", 32'(hsync), 1);
    chk("line7", 32'(lineNumber), 7);
    goto(193);
    chk("hsync_pulse_len", 32'(hsync), 0);
    goto(224);
    chk("line8", 32'(lineNumber), 8);

    count_active(22, 0);
    count_active(23, 24);

    // Field 1 -> field 2 transition.
    act_cnt = 0;
    for (int h = 620; h < 625; h++) check_half(h, 16'hFFFC);
    chk("active_311_313", 32'(act_cnt), 0);
    chk("field_before_f2", 32'(isFieldOdd), 1);
    goto(10000);
    chk("f2_vsync", 32'(vsync), 1);
    chk("f2_field", 32'(isFieldOdd), 0);
    chk("f2_line", 32'(lineNumber), 313);
    chk("f2_hsync_midline", 32'(hsync), 0);
    for (int h = 625; h < 630; h++) check_half(h, 16'hE000);
    for (int h = 630; h < 635; h++) check_half(h, 16'hFFFC);
    check_half(635, 16'hFFFF);

    count_active(320, 0);
    count_active(335, 0);
    count_active(336, 24);
    count_active(622, 24);

    goto(19968);
    chk("line625", 32'(lineNumber), 625);
    check_half(1248, 16'hFFFC);
    check_half(1249, 16'hFFFC);
    chk("field_end_frame", 32'(isFieldOdd), 0);
    goto(20000);
    chk("wrap_vsync", 32'(vsync), 1);
    chk("wrap_hsync", 32'(hsync), 1);
    chk("wrap_line", 32'(lineNumber), 1);
    chk("wrap_field", 32'(isFieldOdd), 1);
    chk("wrap_csync", 32'(csync), 0);

    // frameSync at line 400 (h=798), c=5 of the second frame.
    goto(32772);
    frameSync = 1'b1;
    adv();
    frameSync = 1'b0;
    chk("fs_pre_line", 32'(lineNumber), 400);
    chk("fs_pre_field", 32'(isFieldOdd), 0);
    chk("fs_pre_csync", 32'(csync), 1);
    s_obs = -1;
    adv();
    chk("fs_csync", 32'(csync), 0);
    chk("fs_vsync", 32'(vsync), 1);
    chk("fs_line", 32'(lineNumber), 1);
    chk("fs_field", 32'(isFieldOdd), 1);
    check_half(0, 16'hE000);
    check_half(1, 16'hE000);

    // Reset together with frameSync in the middle of a broad pulse.
    goto(40);
    reset = 1'b1;
    frameSync = 1'b1;
    adv();
    check_reset_vals("rst2");
    frameSync = 1'b0;
    adv();
    reset = 1'b0;
    s_obs = -1;
    adv();
    chk("rst2_vsync", 32'(vsync), 1);
    chk("rst2_line", 32'(lineNumber), 1);
    check_half(0, 16'hE000);
    check_half(1, 16'hE000);
    chk("rst2_vsync_once", 32'(vsync), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csync_generator_pal576i.md
Name: csync_generator_pal576i

Overview:
Generates PAL 576i (625-line, interlaced) composite sync for the SCART output (csync_scartOut). It is the transmit-side counterpart of the csync-to-hsync/vsync regenerator: it emits broad, equalising and line sync pulses and also provides hsync/vsync strobes, field, line number and active-video timing. It runs on the pixel clock x6 domain. An optional frameSync input lets the output be genlocked to regenerated AIV vsync.

Parameters:
LINE_CLKS, 6144, clocks per 64 us line (96 MHz clk); must be even
HSYNC_CLKS, 451, line sync pulse low width (4.7 us)
EQ_CLKS, 226, equalising pulse low width (2.35 us)
BROAD_CLKS, 2621, broad pulse low width (LINE_CLKS/2 - HSYNC_CLKS)
ACTIVE_START, 1008, first active clock within a line (10.5 us)
ACTIVE_END, 6000, first inactive clock after active video (ACTIVE_START + 52 us)

Ports:
clk  input  1  pixel clock x6
reset  input  1  synchronous, active-high reset
frameSync  input  1  1-clk strobe: restart timing at field-1 start (half-line 0, clock 0)
csync  output  1  composite sync, active low
hsync  output  1  1-clk strobe at every line start
vsync  output  1  1-clk strobe at start of each broad-pulse sequence
isFieldOdd  output  1  1 = field 1 (lines 1-312 and the first half of 313)
lineNumber  output  10  current line, 1..625
activeVideo  output  1  high inside the active picture area

Behaviour:
- Counters:
  - c counts 0..HALF-1 within a half-line, where HALF = LINE_CLKS/2.
  - h counts 0..1249 half-lines. Line L, half k maps to h = 2(L-1)+k.
  - c wraps to 0 and increments h. h wraps from 1249 to 0.
- Reset:
  - While reset is high: c=0, h=0, csync=1, hsync=0, vsync=0, isFieldOdd=1, lineNumber=1, activeVideo=0.
  - On the first clk after release, the counters sit at (0,0).
- frameSync:
  - Forces (h,c) to (0,0) on the next clk.
  - reset has priority over frameSync.
  - frameSync asserted when (h,c) is already (0,0) has no visible effect.
- Pulse width selection by h:
  - broad, BROAD_CLKS: h in 0-4 or 625-629.
  - equalising, EQ_CLKS: h in 1245-1249, 5-9, 620-624 or 630-634.
  - line sync, HSYNC_CLKS: any other even h.
  - none: any other odd h.
- csync timing:
  - Registered with one clk latency: csync(n+1) = 0 iff c(n) < width(h(n)).
  - This gives field 1 the sequence 5 pre-eq / 5 broad / 5 post-eq pulses.
  - Field 2 starts with an eq pulse at line 313 and the broad sequence begins at line 313.5.
  - Line 318 has an eq pulse in its first half and nothing at mid-line.
- hsync(n+1) = 1 iff c(n)=0 and h(n) is even.
- vsync(n+1) = 1 iff c(n)=0 and h(n) is 0 or 625.
- Field and line outputs:
  - isFieldOdd is registered: set when h=0,c=0; cleared when h=625,c=0.
  - lineNumber is registered: updates to h/2+1 when c=0 and h is even, so it is valid from the hsync cycle.
- activeVideo:
  - Line position p = c + (h odd ? HALF : 0).
  - Registered: activeVideo(n+1) = 1 iff line(n) is in 23..310 or 336..622 and ACTIVE_START <= p(n) < ACTIVE_END.
- All outputs are registered, and all comparisons are unsigned. c and p are sized to hold LINE_CLKS-1.

Test Plan:
1. Release reset, then observe 3 lines.
   - csync stays 1 during reset.
   - From 1 clk after release: 5 cycles of (0 for 2621 clks, 1 for 451 clks).
   - vsync=1 for exactly 1 clk at the first cycle; isFieldOdd=1; lineNumber=1.
2. Run to line 6 (h=10).
   - csync low 451 clks, then high 5693 clks; no mid-line pulse.
   - hsync period is 6144 clks; lineNumber increments 6,7,8.
3. Run to field 2.
   - From h=620 (clk 1,904,640): eq pulses, 226 clks low every 3072 clks.
   - At clk 1,920,000: vsync strobe, broad pulses begin, isFieldOdd goes 0.
   - Line 318 second half has no pulse.
4. Run full frame.
   - Period is 3,840,000 clks; h wraps 1249->0; lineNumber goes 625->1; isFieldOdd goes 1.
   - activeVideo is high 4992 clks per line on line 23 and line 622, and low on lines 311-335.
5. Pulse frameSync at line 100, clock 3000.
   - Next clk: counters at (0,0).
   - The clk after: csync=0 (broad), vsync=1, lineNumber=1, isFieldOdd=1.
6. Assert reset and frameSync together mid-broad pulse.
   - Next clk: all outputs at reset values (csync=1).
   - After release: timing restarts exactly as in scenario 1.
